// File: rtl/mouse_pos_tracker.sv
// PS/2 mouse packet assembler with clamped absolute X/Y, bus-readable registers and per-packet IRQ.
// Define MOUSE_POS_WRITE_EN to let bus writes to BASE+1/BASE+2 set X/Y directly.
module mouse_pos_tracker #(
  parameter logic [7:0]  BASE_ADDR = 8'hA0,
  parameter logic [7:0]  MAX_X     = 8'd159,
  parameter logic [7:0]  MAX_Y     = 8'd119,
  parameter logic [7:0]  INIT_X    = 8'd80,
  parameter logic [7:0]  INIT_Y    = 8'd60,
  parameter logic [19:0] TIMEOUT   = 20'd200000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  // state    | meaning
  // S_STATUS | waiting for a status byte (bit3 set); other bytes dropped to resync
  // S_DX     | status latched, waiting for X delta (gap timer running)
  // S_DY     | X delta latched, waiting for Y delta (gap timer running)
  typedef enum logic [1:0] {S_STATUS, S_DX, S_DY} state_t;

  state_t      state_q;
  logic [2:0]  btn_pend_q;
  logic        sx_q, sy_q, ovx_q, ovy_q;
  logic [7:0]  dx_q, dy_q;
  logic [19:0] gap_q;
  logic        upd_pend_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_STATUS;
      btn_pend_q <= 3'd0;
      sx_q       <= 1'b0;
      sy_q       <= 1'b0;
      ovx_q      <= 1'b0;
      ovy_q      <= 1'b0;
      dx_q       <= 8'd0;
      dy_q       <= 8'd0;
      gap_q      <= 20'd0;
      upd_pend_q <= 1'b0;
    end else begin
      upd_pend_q <= 1'b0;
      case (state_q)
        S_STATUS: begin
          if (BYTE_VALID && BYTE_IN[3]) begin
            ovy_q      <= BYTE_IN[7];
            ovx_q      <= BYTE_IN[6];
            sy_q       <= BYTE_IN[5];
            sx_q       <= BYTE_IN[4];
            btn_pend_q <= BYTE_IN[2:0];
            gap_q      <= TIMEOUT - 20'd1;
            state_q    <= S_DX;
          end
        end
        S_DX: begin
          if (BYTE_VALID) begin
            dx_q    <= BYTE_IN;
            gap_q   <= TIMEOUT - 20'd1;
            state_q <= S_DY;
          end else if (gap_q == 20'd0) begin
            state_q <= S_STATUS;
          end else begin
            gap_q <= gap_q - 20'd1;
          end
        end
        S_DY: begin
          if (BYTE_VALID) begin
            dy_q       <= BYTE_IN;
            upd_pend_q <= 1'b1;
            state_q    <= S_STATUS;
          end else if (gap_q == 20'd0) begin
            state_q <= S_STATUS;
          end else begin
            gap_q <= gap_q - 20'd1;
          end
        end
        default: state_q <= S_STATUS;
      endcase
    end
  end

  // 10-bit signed sum covers pos+255 and pos-256 without wrapping.
  function automatic logic [7:0] move_axis(input logic [7:0] pos, input logic [7:0] mag,
                                           input logic sgn, input logic ovf,
                                           input logic [7:0] max_v);
    logic [9:0] delta;
    logic [9:0] sum;
    delta = ovf ? 10'd0 : {sgn, sgn, mag};
    sum   = {2'b00, pos} + delta;
    if (sum[9])
      return 8'd0;
    else if (sum > {2'b00, max_v})
      return max_v;
    else
      return sum[7:0];
  endfunction

  logic [7:0] x_q, x_d, y_q, y_d, cnt_q, cnt_d;
  logic [2:0] btn_q, btn_d;
  logic       irq_q, irq_d;
  logic [7:0] bus_off;

  assign bus_off = BUS_ADDR - BASE_ADDR;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    btn_d = btn_q;
    cnt_d = cnt_q;
    irq_d = irq_q;
    if (BUS_INTERRUPT_ACK)
      irq_d = 1'b0;
    if (upd_pend_q) begin
      x_d   = move_axis(x_q, dx_q, sx_q, ovx_q, MAX_X);
      y_d   = move_axis(y_q, dy_q, sy_q, ovy_q, MAX_Y);
      btn_d = btn_pend_q;
      cnt_d = cnt_q + 8'd1;
      irq_d = 1'b1;
    end
`ifdef MOUSE_POS_WRITE_EN
    // A firmware write overrides any packet delta landing on the same axis this edge.
    if (BUS_WE && (bus_off == 8'd1))
      x_d = (BUS_DATA > MAX_X) ? MAX_X : BUS_DATA;
    if (BUS_WE && (bus_off == 8'd2))
      y_d = (BUS_DATA > MAX_Y) ? MAX_Y : BUS_DATA;
`endif
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= INIT_X;
      y_q   <= INIT_Y;
      btn_q <= 3'd0;
      cnt_q <= 8'd0;
      irq_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      btn_q <= btn_d;
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign BUS_INTERRUPT_RAISE = irq_q;

  logic       rd_hit;
  logic [7:0] rd_mux;
  logic       rd_en_q;
  logic [7:0] rd_data_q;

  assign rd_hit = !BUS_WE && (bus_off < 8'd4);

  always_comb begin
    rd_mux = 8'd0;
    case (bus_off[1:0])
      2'd0: rd_mux = {5'b00000, btn_q};
      2'd1: rd_mux = x_q;
      2'd2: rd_mux = y_q;
      2'd3: rd_mux = cnt_q;
      default: rd_mux = 8'd0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q   <= 1'b0;
      rd_data_q <= 8'd0;
    end else begin
      rd_en_q <= rd_hit;
      if (rd_hit)
        rd_data_q <= rd_mux;
    end
  end

  assign BUS_DATA = rd_en_q ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Bench for mouse_pos_tracker: packets driven as bytes, register reads checked through a scoreboard.
module tb_mouse_pos_tracker;
  localparam logic [7:0] BASE = 8'hA0;
  localparam int TMO = 50;

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_in = 8'd0;
  logic       byte_valid = 1'b0;
  wire  [7:0] bus_data;
  logic [7:0] bus_addr = 8'd0;
  logic       bus_we = 1'b0;
  logic       irq;
  logic       ack = 1'b0;
  logic [7:0] tb_wdata = 8'd0;
  logic       tb_drv = 1'b0;

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;
  always #5 clk_sys = ~clk_sys;

  mouse_pos_tracker #(.TIMEOUT(20'(TMO))) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .BYTE_IN(byte_in), .BYTE_VALID(byte_valid),
    .BUS_DATA(bus_data), .BUS_ADDR(bus_addr), .BUS_WE(bus_we),
    .BUS_INTERRUPT_RAISE(irq), .BUS_INTERRUPT_ACK(ack));

  int checks = 0, failures = 0;
  int exp_q[$];
  string tag_q[$];
  logic req_drv = 1'b0, rd_seen = 1'b0;
  int mx, my, mbtn, mcnt;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk_sys) rd_seen <= req_drv;
  always @(negedge clk_sys) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
      else chk(tag_q.pop_front(), int'(bus_data), exp_q.pop_front());
    end
  end

  function automatic int axis(input int pos, input int mag, input bit sgn, input bit ovf, input int maxv);
    int d, n;
    d = ovf ? 0 : (sgn ? mag - 256 : mag);
    n = pos + d;
    if (n < 0) return 0;
    if (n > maxv) return maxv;
    return n;
  endfunction

  task automatic model_pkt(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
    mx = axis(mx, int'(dx), s[4], s[6], 159);
    my = axis(my, int'(dy), s[5], s[7], 119);
    mbtn = int'(s[2:0]);
    mcnt = (mcnt + 1) % 256;
  endtask

  task automatic model_reset();
    mx = 80; my = 60; mbtn = 0; mcnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_sys); byte_in = b; byte_valid = 1'b1;
    @(negedge clk_sys); byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic rd(input logic [7:0] a, input int e, input string t);
    @(negedge clk_sys); bus_addr = a; bus_we = 1'b0; req_drv = 1'b1;
    exp_q.push_back(e); tag_q.push_back(t);
    @(negedge clk_sys); bus_addr = 8'h00; req_drv = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic rd_all();
    rd(BASE + 8'd1, mx, "rd_x");
    rd(BASE + 8'd2, my, "rd_y");
    rd(BASE, mbtn, "rd_status");
    rd(BASE + 8'd3, mcnt, "rd_cnt");
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk_sys); bus_addr = a; bus_we = 1'b1; tb_wdata = d; tb_drv = 1'b1;
    @(negedge clk_sys); bus_addr = 8'h00; bus_we = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk_sys); ack = 1'b1;
    @(negedge clk_sys); ack = 1'b0;
    chk("irq_clr", int'(irq), 0);
  endtask

  task automatic send_pkt(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy, input int gap);
    send_byte(s); idle(gap);
    send_byte(dx); idle(gap);
    send_byte(dy);
    chk("irq_early", int'(irq), 0);
    @(negedge clk_sys);
    chk("irq_set", int'(irq), 1);
    model_pkt(s, dx, dy);
    do_ack();
    rd_all();
  endtask

  initial begin
    model_reset();
    idle(3);
    rst_n = 1'b1;
    chk("irq_rst", int'(irq), 0);
    rd_all();

    send_pkt(8'h09, 8'h05, 8'h03, 0);
    send_pkt(8'h18, 8'h9C, 8'h00, 0);
    send_pkt(8'h08, 8'hFF, 8'h7F, 0);
    send_pkt(8'h08, 8'hFF, 8'h7F, 0);
    send_pkt(8'h28, 8'h00, 8'h9C, 0);
    send_pkt(8'h58, 8'h10, 8'h01, 0);
    send_pkt(8'h9F, 8'hF6, 8'h10, 0);

    send_byte(8'h00);
    send_pkt(8'h08, 8'h02, 8'h02, 0);

    send_byte(8'h08); send_byte(8'h10);
    idle(TMO + 10);
    chk("irq_after_timeout", int'(irq), 0);
    send_pkt(8'h08, 8'h01, 8'h01, 0);
    send_pkt(8'h0A, 8'h03, 8'h04, TMO - 10);

    send_byte(8'h08); send_byte(8'h01); send_byte(8'h01);
    ack = 1'b1;
    @(negedge clk_sys); ack = 1'b0;
    chk("irq_ack_coincide", int'(irq), 1);
    model_pkt(8'h08, 8'h01, 8'h01);
    do_ack();
    rd_all();

    wr(BASE + 8'd1, 8'hC8);
    wr(BASE + 8'd2, 8'h05);
    wr(BASE + 8'd3, 8'h55);
    wr(BASE, 8'h07);
`ifdef MOUSE_POS_WRITE_EN
    mx = 159; my = 5;
`endif
    rd_all();

    send_byte(8'h08); send_byte(8'h03); send_byte(8'h03);
    bus_addr = BASE + 8'd1; bus_we = 1'b1; tb_wdata = 8'h10; tb_drv = 1'b1;
    @(negedge clk_sys); bus_addr = 8'h00; bus_we = 1'b0; tb_drv = 1'b0;
    chk("irq_wr_same_edge", int'(irq), 1);
    model_pkt(8'h08, 8'h03, 8'h03);
`ifdef MOUSE_POS_WRITE_EN
    mx = 16;
`endif
    do_ack();
    rd_all();

    while (mcnt != 255) begin
      send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
      model_pkt(8'h08, 8'h00, 8'h00);
    end
    do_ack();
    rd(BASE + 8'd3, mcnt, "rd_cnt_255");
    send_pkt(8'h08, 8'h00, 8'h00, 0);

    send_byte(8'h08); send_byte(8'h05);
    @(negedge clk_sys); rst_n = 1'b0;
    @(negedge clk_sys); rst_n = 1'b1;
    model_reset();
    send_byte(8'h03);
    rd_all();

    send_byte(8'h0B); send_byte(8'h05); send_byte(8'h05);
    rst_n = 1'b0;
    @(negedge clk_sys); rst_n = 1'b1;
    idle(2);
    chk("irq_lost_on_reset", int'(irq), 0);
    rd_all();

    idle(3);
    chk("rd_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
